// File: rtl/memory_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus_master
// Brief    : Single-word request initiator for a shared bidirectional memory
//            bus. Sequences enable/read_write/address/data cycles, owns the
//            tri-state data lines, inserts turnaround cycles and supports a
//            fixed number of wait states per access.
// Revision : 1.0 - initial release
// ============================================================================
module memory_bus_master #(
  parameter int address_size = 16,
  parameter int wait_states  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [address_size-1:0] req_address,
  input  logic [15:0]             req_wdata,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [15:0]             resp_rdata,
  output logic                    mem_enable,
  output logic                    mem_read_write,
  output logic [address_size-1:0] mem_address,
  inout  wire  [15:0]             mem_data
);

  // Last wait-state count value before leaving WRITE/READ.
  localparam logic [3:0] WAIT_LAST = 4'(wait_states);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    TURN  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_count;
  logic [15:0] wdata_q;
  logic        drive_data;
  logic        accept;
  logic        wait_done;

  assign accept    = (state == IDLE) && req_valid;
  assign wait_done = (wait_count == WAIT_LAST);

  // Next-state and per-state output decode; outputs depend on state only.
  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_enable     = 1'b0;
    mem_read_write = 1'b1;
    drive_data     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = req_write ? WRITE : SETUP;
        end
      end
      SETUP: begin
        state_next = READ;
      end
      WRITE: begin
        mem_enable     = 1'b1;
        mem_read_write = 1'b0;
        drive_data     = 1'b1;
        if (wait_done) begin
          state_next = TURN;
        end
      end
      READ: begin
        mem_enable = 1'b1;
        if (wait_done) begin
          state_next = TURN;
        end
      end
      TURN: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The master only ever drives the data lines while in WRITE.
  assign mem_data = drive_data ? wdata_q : 16'bz;

  // State register, wait counter, operand latches and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_count  <= 4'd0;
      mem_address <= '0;
      wdata_q     <= 16'h0000;
      resp_rdata  <= 16'h0000;
    end else begin
      state <= state_next;
      // Counter restarts whenever the state changes, so it is 0 on entry
      // to WRITE/READ and counts cycles spent there.
      if (state_next != state) begin
        wait_count <= 4'd0;
      end else begin
        wait_count <= wait_count + 4'd1;
      end
      if (accept) begin
        mem_address <= req_address;
        wdata_q     <= req_wdata;
      end
      // Only the final READ edge is trusted; earlier cycles may still be
      // within the memory's access time.
      if ((state == READ) && wait_done) begin
        resp_rdata <= mem_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_bus_master
// Brief    : Scoreboard bench for memory_bus_master. Three instances with
//            0, 3 and 2 wait states, each attached to a 16-word memory model
//            and a bus keeper that drives 0 whenever the bus is disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bus_master;

  localparam int N = 3;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] reset;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_write;
  logic [15:0]  req_address [N];
  logic [15:0]  req_wdata   [N];
  wire  [N-1:0] req_ready;
  wire  [N-1:0] resp_valid;
  wire  [N-1:0] mem_enable;
  wire  [N-1:0] mem_read_write;
  wire  [15:0]  resp_rdata  [N];
  wire  [15:0]  mem_address [N];
  wire  [15:0]  bus_obs     [N];

  exp_t        sbq [N][$];
  logic [15:0] last_rd  [N];
  int          last_acc [N];
  int          checks  = 0;
  int          errors  = 0;
  logic        started = 1'b0;

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int WSG = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    wire  [15:0] bus;
    logic [15:0] mem [16];
    logic        inited = 1'b0;
    int          rd_cnt = 0;
    int          en_cnt = 0;
    int          prev_mode = 0;
    int          cur_mode;
    exp_t        e;
    logic [15:0] rd_val;

    memory_bus_master #(
      .address_size(16),
      .wait_states (WSG)
    ) u_dut (
      .clk           (clk),
      .reset         (reset[g]),
      .req_valid     (req_valid[g]),
      .req_write     (req_write[g]),
      .req_address   (req_address[g]),
      .req_wdata     (req_wdata[g]),
      .req_ready     (req_ready[g]),
      .resp_valid    (resp_valid[g]),
      .resp_rdata    (resp_rdata[g]),
      .mem_enable    (mem_enable[g]),
      .mem_read_write(mem_read_write[g]),
      .mem_address   (mem_address[g]),
      .mem_data      (bus)
    );

    // Memory returns junk until its access time (WSG cycles) has elapsed.
    assign rd_val     = (rd_cnt == WSG) ? mem[mem_address[g][3:0]] : 16'hDEAD;
    assign bus        = !mem_enable[g] ? 16'h0000 :
                        (mem_read_write[g] ? rd_val : 16'hzzzz);
    assign bus_obs[g] = bus;

    always @(posedge clk) begin
      if (!inited) begin
        for (int k = 0; k < 16; k++) mem[k] <= 16'h1000 + 16'(k);
        mem[2] <= 16'h1234;
        inited <= 1'b1;
      end else if (mem_enable[g] && !mem_read_write[g]) begin
        mem[mem_address[g][3:0]] <= bus;
      end
      if (mem_enable[g] && mem_read_write[g]) rd_cnt <= rd_cnt + 1;
      else rd_cnt <= 0;
    end

    always @(posedge clk) begin
      #2;
      if (resp_valid[g]) begin
        if (sbq[g].size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e = sbq[g].pop_front();
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_rdata", {16'h0, resp_rdata[g]}, {16'h0, e.rdata});
        end
      end
      if (started) begin
        if (!mem_enable[g]) chk("bus_released", {16'h0, bus}, 32'h0);
        cur_mode = !mem_enable[g] ? 0 : (mem_read_write[g] ? 1 : 2);
        chk("turnaround", {31'h0, (prev_mode != 0) && (cur_mode != 0) && (prev_mode != cur_mode)}, 32'h0);
        prev_mode = cur_mode;
        if (reset[g]) begin
          en_cnt = 0;
        end else if (mem_enable[g]) begin
          en_cnt++;
        end else if (en_cnt != 0) begin
          chk("enable_len", en_cnt, WSG + 1);
          en_cnt = 0;
        end
      end
    end
  end

  task automatic req(input int i, input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] exp_rd, input int gap, input bit abort);
    int   n;
    int   k;
    exp_t e;
    @(negedge clk);
    req_valid[i]   = 1'b1;
    req_write[i]   = wr;
    req_address[i] = a;
    req_wdata[i]   = d;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    @(posedge clk);
    #2;
    k = cyc;
    if (gap > 0) chk("accept_gap", k - last_acc[i], gap);
    last_acc[i] = k;
    chk("addr_at_accept", {16'h0, mem_address[i]}, {16'h0, a});
    if (wr) begin
      chk("write_enable", {30'h0, mem_enable[i], mem_read_write[i]}, 32'h2);
      chk("write_drive", {16'h0, bus_obs[i]}, {16'h0, d});
    end
    if (!abort) begin
      e.cyc   = k + 1 + ws_of(i) + (wr ? 0 : 1);
      e.rdata = wr ? last_rd[i] : exp_rd;
      if (!wr) last_rd[i] = exp_rd;
      sbq[i].push_back(e);
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset     = '1;
    req_valid = 3'b001;
    req_write = '0;
    for (int i = 0; i < N; i++) begin
      req_address[i] = 16'h0007;
      req_wdata[i]   = 16'h1111;
      last_rd[i]     = 16'h0000;
      last_acc[i]    = 0;
    end

    // Reset with a pending request: reset wins, nothing is accepted.
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_enable", {31'h0, mem_enable[0]}, 32'd0);
    chk("rst_read_write", {31'h0, mem_read_write[0]}, 32'd1);
    chk("rst_bus", {16'h0, bus_obs[0]}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready[0]}, 32'd1);
    chk("rst_resp_valid", {31'h0, resp_valid[0]}, 32'd0);
    chk("rst_resp_rdata", {16'h0, resp_rdata[0]}, 32'h0);
    chk("rst_mem_address", {16'h0, mem_address[0]}, 32'h0);
    @(negedge clk);
    reset     = '0;
    req_valid = '0;
    @(posedge clk);
    #2;
    chk("rst_not_accepted", {30'h0, req_ready[0], mem_enable[0]}, 32'h2);
    started = 1'b1;

    // Zero wait states: write then read back.
    req(0, 1'b1, 16'h0005, 16'hBEEF, 16'h0000, 0, 1'b0);
    idle(0);
    req(0, 1'b0, 16'h0005, 16'h0000, 16'hBEEF, 0, 1'b0);
    idle(0);

    // Back-to-back alternating write/read with req_valid held high.
    req(0, 1'b1, 16'h0001, 16'hA5A5, 16'h0000, 0, 1'b0);
    req(0, 1'b0, 16'h0001, 16'h0000, 16'hA5A5, 3, 1'b0);
    req(0, 1'b1, 16'h0001, 16'h5A5A, 16'h0000, 4, 1'b0);
    req(0, 1'b0, 16'h0001, 16'h0000, 16'h5A5A, 3, 1'b0);
    idle(0);

    // Full-width address passes through; memory aliases 0x0013 onto 0x0003.
    req(0, 1'b1, 16'h0013, 16'h0F0F, 16'h0000, 0, 1'b0);
    idle(0);
    req(0, 1'b0, 16'h0003, 16'h0000, 16'h0F0F, 0, 1'b0);
    idle(0);

    // Three wait states: read data is only correct in the last READ cycle.
    req(1, 1'b0, 16'h0002, 16'h0000, 16'h1234, 0, 1'b0);
    idle(1);
    req(1, 1'b1, 16'h0009, 16'h9999, 16'h0000, 0, 1'b0);
    idle(1);
    req(1, 1'b0, 16'h0009, 16'h0000, 16'h9999, 0, 1'b0);
    idle(1);

    // Two wait states: reset in the second WRITE cycle aborts the access.
    req(2, 1'b0, 16'h0004, 16'h0000, 16'h1004, 0, 1'b0);
    idle(2);
    n = 0;
    while (sbq[2].size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    req(2, 1'b1, 16'h0006, 16'h6666, 16'h0000, 0, 1'b1);
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    reset[2] = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_mem_enable", {31'h0, mem_enable[2]}, 32'd0);
    chk("abort_bus", {16'h0, bus_obs[2]}, 32'h0);
    chk("abort_resp_rdata", {16'h0, resp_rdata[2]}, 32'h0);
    chk("abort_req_ready", {31'h0, req_ready[2]}, 32'd1);
    @(negedge clk);
    reset[2]   = 1'b0;
    last_rd[2] = 16'h0000;
    repeat (4) @(posedge clk);
    req(2, 1'b1, 16'h000A, 16'h0A0A, 16'h0000, 0, 1'b0);
    idle(2);
    req(2, 1'b0, 16'h000A, 16'h0000, 16'h0A0A, 0, 1'b0);
    idle(2);

    n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", sbq[0].size() + sbq[1].size() + sbq[2].size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
